// File: rtl/div_unit_if.sv
//------------------------------------------------------------------------------
// Module : div_unit_if
// Start/Busy/Done handshake bundle between the pipeline and the divider.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Sign;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             DivZero;

   modport master (
      output Start, A, B, Sign,
      input  Busy, Done, Q, R, DivZero
   );

   modport slave (
      input  Start, A, B, Sign,
      output Busy, Done, Q, R, DivZero
   );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// Module : div_unit
// Restoring iterative divider for MIPS DIV/DIVU: quotient to LO, remainder to HI.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  bus
);

   localparam int              c_CW   = $clog2(WIDTH);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_rem;
   logic [WIDTH-1:0]  r_quo;
   logic [WIDTH-1:0]  r_dvs;
   logic [WIDTH-1:0]  r_araw;
   logic [c_CW-1:0]   r_cnt;
   logic              r_qneg;
   logic              r_rneg;
   logic              r_dz;
   logic              r_busy;
   logic              r_done;
   logic              r_divzero;
   logic [WIDTH-1:0]  r_q;
   logic [WIDTH-1:0]  r_r;

   logic [WIDTH-1:0]  w_amag;
   logic [WIDTH-1:0]  w_bmag;
   logic [WIDTH:0]    w_shift;
   logic [WIDTH:0]    w_trial;

   // Magnitudes are plain WIDTH-bit unsigned, so the most negative value maps to itself.
   assign w_amag = (bus.Sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign w_bmag = (bus.Sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;

   // The partial remainder always stays below the divisor, so the shifted
   // value fits WIDTH+1 bits and t[WIDTH] is a clean borrow indicator.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dvs};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_araw    <= '0;
         r_cnt     <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_dz      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_divzero <= 1'b0;
         r_q       <= '0;
         r_r       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.Start) begin
                  r_busy <= 1'b1;
                  r_quo  <= bus.Sign ? w_amag : bus.A;
                  r_dvs  <= bus.Sign ? w_bmag : bus.B;
                  r_araw <= bus.A;
                  r_qneg <= bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  r_rneg <= bus.Sign & bus.A[WIDTH-1];
                  r_rem  <= '0;
                  r_cnt  <= '0;
                  if (bus.B == '0) begin
                     r_dz    <= 1'b1;
                     r_state <= S_FIX;
                  end else begin
                     r_dz    <= 1'b0;
                     r_state <= S_RUN;
                  end
               end
            end

            S_RUN: begin
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_state <= S_FIX;
               end
            end

            S_FIX: begin
               if (r_dz) begin
                  r_q       <= '1;
                  r_r       <= r_araw;
                  r_divzero <= 1'b1;
               end else begin
                  r_q       <= r_qneg ? -r_quo : r_quo;
                  r_r       <= r_rneg ? -r_rem : r_rem;
                  r_divzero <= 1'b0;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.Busy    = r_busy;
   assign bus.Done    = r_done;
   assign bus.Q       = r_q;
   assign bus.R       = r_r;
   assign bus.DivZero = r_divzero;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
//------------------------------------------------------------------------------
// Module : tb_div_unit
// Directed-vector bench for div_unit (WIDTH=32).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive a request; returns #1 after the sampling edge (edge 0).
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      bus.Start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.Sign  = s;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
   endtask

   // Counts edges until Done; lat=-1 on timeout, busy_ok=0 if Busy dropped early.
   task automatic wait_done(output int lat, output logic busy_ok);
      lat     = -1;
      busy_ok = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.Done) begin
            lat = i;
            break;
         end
         if (!bus.Busy) busy_ok = 1'b0;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int exp_lat, input logic [31:0] eq,
                         input logic [31:0] er, input logic edz);
      int   lat;
      logic bok;
      start_op(a, b, s);
      chk({tag, ".busy_rise"}, 64'(bus.Busy), 64'd1);
      wait_done(lat, bok);
      chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, ".busy_held"}, 64'(bok), 64'd1);
      chk({tag, ".q"}, 64'(bus.Q), 64'(eq));
      chk({tag, ".r"}, 64'(bus.R), 64'(er));
      chk({tag, ".divzero"}, 64'(bus.DivZero), 64'(edz));
      chk({tag, ".busy_fall"}, 64'(bus.Busy), 64'd0);
      @(posedge clk);
      #1;
      chk({tag, ".done_pulse"}, 64'(bus.Done), 64'd0);
      chk({tag, ".q_hold"}, 64'(bus.Q), 64'(eq));
   endtask

   initial begin
      int   lat;
      logic bok;
      logic seen;
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b0;
      bus.Start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Sign  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", 64'(bus.Busy), 64'd0);
      chk("reset.done", 64'(bus.Done), 64'd0);
      chk("reset.q", 64'(bus.Q), 64'd0);
      chk("reset.r", 64'(bus.R), 64'd0);
      chk("reset.divzero", 64'(bus.DivZero), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      run_op("u100_7",   32'd100,        32'd7,          1'b0, 33, 32'd14,         32'd2,          1'b0);
      run_op("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 33, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
      run_op("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, 33, 32'hFFFF_FFFD,  32'd1,          1'b0);
      run_op("smin_-1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 33, 32'h8000_0000,  32'd0,          1'b0);
      run_op("umin_max", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 33, 32'd0,          32'h8000_0000,  1'b0);
      run_op("s0_5",     32'd0,          32'd5,          1'b1, 33, 32'd0,          32'd0,          1'b0);
      run_op("divzero",  32'h0000_1234,  32'd0,          1'b1, 1,  32'hFFFF_FFFF,  32'h0000_1234,  1'b1);
      run_op("u20_6",    32'd20,         32'd6,          1'b0, 33, 32'd3,          32'd2,          1'b0);

      // Start pulses sampled at edges 5 and 20 must be ignored.
      start_op(32'd1000, 32'd10, 1'b0);
      lat = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (bus.Done) begin
            lat = e;
            break;
         end
         bus.Start = (e == 4 || e == 19);
         bus.A     = 32'd9;
         bus.B     = 32'd3;
      end
      chk("ign.latency", 64'(lat), 64'd33);
      chk("ign.q", 64'(bus.Q), 64'd100);
      chk("ign.r", 64'(bus.R), 64'd0);

      // Back-to-back start in the Done cycle.
      bus.Start = 1'b1;
      bus.A     = 32'd9;
      bus.B     = 32'd3;
      bus.Sign  = 1'b0;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      chk("b2b.busy", 64'(bus.Busy), 64'd1);
      chk("b2b.q_prev", 64'(bus.Q), 64'd100);
      wait_done(lat, bok);
      chk("b2b.latency", 64'(lat), 64'd33);
      chk("b2b.q", 64'(bus.Q), 64'd3);
      chk("b2b.r", 64'(bus.R), 64'd0);

      // Asynchronous reset in the middle of an iteration.
      @(posedge clk);
      #1;
      start_op(32'd1000, 32'd7, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("arst.busy", 64'(bus.Busy), 64'd0);
      chk("arst.done", 64'(bus.Done), 64'd0);
      chk("arst.q", 64'(bus.Q), 64'd0);
      chk("arst.r", 64'(bus.R), 64'd0);
      chk("arst.divzero", 64'(bus.DivZero), 64'd0);
      seen = 1'b0;
      for (int e = 0; e < 43; e++) begin
         @(posedge clk);
         #1;
         if (e == 2) reset = 1'b1;
         if (bus.Done) seen = 1'b1;
      end
      chk("arst.no_done", 64'(seen), 64'd0);
      run_op("u50_5", 32'd50, 32'd5, 1'b0, 33, 32'd10, 32'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
